// File: rtl/counter_checker.sv
// On-chip monitor for the 4-bit multi-mode counter: predicts Q/load one edge ahead and flags
// divergence. Optional first-error capture is enabled with `define CHK_FIRST_ERR_LOG_EN.
module counter_checker #(
    parameter logic [1:0]  Q_P_ONE     = 2'b00,
    parameter logic [1:0]  Q_M_ONE     = 2'b01,
    parameter logic [1:0]  Q_M_THREE   = 2'b10,
    parameter logic [1:0]  Q_D         = 2'b11,
    parameter int unsigned ERR_W       = 8,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             dut_reset_i,
    input  logic             dut_enable_i,
    input  logic [1:0]       dut_mode_i,
    input  logic [3:0]       dut_d_i,
    input  logic [3:0]       dut_q_i,
    input  logic             dut_load_i,
    output logic [3:0]       q_exp_o,
    output logic             rco_exp_o,
    output logic             synced_o,
    output logic             mismatch_o,
    output logic             fail_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [15:0]      chk_count_o
`ifdef CHK_FIRST_ERR_LOG_EN
    ,
    output logic [3:0]       first_exp_q_o,
    output logic [3:0]       first_act_q_o,
    output logic [15:0]      first_err_cyc_o
`endif
);

    typedef enum logic [1:0] {
        StUnsync = 2'b00,
        StTrack  = 2'b01,
        StFail   = 2'b10
    } state_e;

    localparam logic [ERR_W-1:0] ErrInc = {{(ERR_W - 1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

    state_e             state_q, state_d;
    logic [3:0]         mq_q, mq_d;
    logic               mload_q, mload_d;
    logic               mrco_q, mrco_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [15:0]        chk_q, chk_d;
    logic               mis_q, mis_d;
    logic               deterministic;
    logic               cmp_miss;

    // Reference model of the counter, updated every edge whatever the checker state.
    always_comb begin
        mq_d    = mq_q;
        mload_d = mload_q;
        mrco_d  = mrco_q;
        if (dut_reset_i) begin
            mq_d    = 4'd0;
            mload_d = 1'b0;
            mrco_d  = 1'b0;
        end else if (!dut_enable_i) begin
            mq_d    = 4'd0;
            mload_d = (dut_mode_i == Q_D);
            if (dut_mode_i == Q_D) begin
                mrco_d = 1'b0;
            end
        end else begin
            case (dut_mode_i)
                Q_P_ONE: begin
                    mq_d    = mq_q + 4'd1;
                    mrco_d  = (mq_q == 4'hF);
                    mload_d = 1'b0;
                end
                Q_M_ONE: begin
                    mq_d    = mq_q - 4'd1;
                    mrco_d  = (mq_q == 4'h0);
                    mload_d = 1'b0;
                end
                Q_M_THREE: begin
                    mq_d    = mq_q - 4'd3;
                    mrco_d  = (mq_q <= 4'd2);
                    mload_d = 1'b0;
                end
                default: begin
                    mq_d    = dut_d_i;
                    mload_d = 1'b1;
                    mrco_d  = 1'b0;
                end
            endcase
        end
    end

    // Any of these leaves the model state independent of history.
    assign deterministic = dut_reset_i | ~dut_enable_i | (dut_mode_i == Q_D);
    assign cmp_miss      = (dut_q_i != mq_q) | (dut_load_i != mload_q);

`ifdef CHK_FIRST_ERR_LOG_EN
    logic        logged_q, logged_d;
    logic [3:0]  fexp_q, fexp_d;
    logic [3:0]  fact_q, fact_d;
    logic [15:0] fcyc_q, fcyc_d;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        chk_d   = chk_q;
        mis_d   = 1'b0;
`ifdef CHK_FIRST_ERR_LOG_EN
        logged_d = logged_q;
        fexp_d   = fexp_q;
        fact_d   = fact_q;
        fcyc_d   = fcyc_q;
`endif
        if (clear_i) begin
            state_d = StUnsync;
            err_d   = '0;
            chk_d   = '0;
`ifdef CHK_FIRST_ERR_LOG_EN
            logged_d = 1'b0;
            fexp_d   = '0;
            fact_d   = '0;
            fcyc_d   = '0;
`endif
        end else begin
            case (state_q)
                StUnsync: begin
                    if (deterministic) begin
                        state_d = StTrack;
                    end
                end
                StTrack: begin
                    if (chk_q != 16'hFFFF) begin
                        chk_d = chk_q + 16'd1;
                    end
                    if (cmp_miss) begin
                        mis_d = 1'b1;
                        if (err_q != ErrMax) begin
                            err_d = err_q + ErrInc;
                        end
                        if (STOP_ON_ERR) begin
                            state_d = StFail;
                        end
`ifdef CHK_FIRST_ERR_LOG_EN
                        // Cycle index is the compare count including this cycle.
                        if (!logged_q) begin
                            logged_d = 1'b1;
                            fexp_d   = mq_q;
                            fact_d   = dut_q_i;
                            fcyc_d   = chk_d;
                        end
`endif
                    end
                end
                StFail: begin
                    state_d = StFail;
                end
                default: begin
                    state_d = StUnsync;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StUnsync;
            mq_q    <= 4'd0;
            mload_q <= 1'b0;
            mrco_q  <= 1'b0;
            err_q   <= '0;
            chk_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mq_q    <= mq_d;
            mload_q <= mload_d;
            mrco_q  <= mrco_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
            mis_q   <= mis_d;
        end
    end

`ifdef CHK_FIRST_ERR_LOG_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            logged_q <= 1'b0;
            fexp_q   <= '0;
            fact_q   <= '0;
            fcyc_q   <= '0;
        end else begin
            logged_q <= logged_d;
            fexp_q   <= fexp_d;
            fact_q   <= fact_d;
            fcyc_q   <= fcyc_d;
        end
    end

    assign first_exp_q_o   = fexp_q;
    assign first_act_q_o   = fact_q;
    assign first_err_cyc_o = fcyc_q;
`endif

    assign q_exp_o     = mq_q;
    assign rco_exp_o   = mrco_q;
    assign synced_o    = (state_q == StTrack);
    assign fail_o      = (state_q == StFail);
    assign mismatch_o  = mis_q;
    assign err_count_o = err_q;
    assign chk_count_o = chk_q;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: two instances (continue / stop on error) judged against a
// behavioural counter and checker model; first-error log tested when CHK_FIRST_ERR_LOG_EN is set.
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       dut_reset;
    logic       dut_enable;
    logic [1:0] dut_mode;
    logic [3:0] dut_d;
    logic [3:0] dut_q;
    logic       dut_load;

    logic [3:0]  q_exp0, q_exp1;
    logic        rco0, rco1, synced0, synced1, mis0, mis1, fail0, fail1;
    logic [7:0]  err0, err1;
    logic [15:0] chk0, chk1;
`ifdef CHK_FIRST_ERR_LOG_EN
    logic [3:0]  fexp0, fexp1, fact0, fact1;
    logic [15:0] fcyc0, fcyc1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference: checker model (rq/rload/rrco), per-instance verdict state, and an ideal counter.
    int   rq, cq;
    bit   rload, rrco, cload, crco;
    int   st[2];
    int   errs[2];
    int   chks[2];
    bit   mis[2];
    bit   logged;
    int   fexp, fact, fcyc;

    always #5 clk = ~clk;

    counter_checker #(.ERR_W(8), .STOP_ON_ERR(1'b0)) u_dut0 (
        .clk_i(clk), .reset_ni(reset_n), .clear_i(clear), .dut_reset_i(dut_reset),
        .dut_enable_i(dut_enable), .dut_mode_i(dut_mode), .dut_d_i(dut_d), .dut_q_i(dut_q),
        .dut_load_i(dut_load), .q_exp_o(q_exp0), .rco_exp_o(rco0), .synced_o(synced0),
        .mismatch_o(mis0), .fail_o(fail0), .err_count_o(err0), .chk_count_o(chk0)
`ifdef CHK_FIRST_ERR_LOG_EN
        , .first_exp_q_o(fexp0), .first_act_q_o(fact0), .first_err_cyc_o(fcyc0)
`endif
    );

    counter_checker #(.ERR_W(8), .STOP_ON_ERR(1'b1)) u_dut1 (
        .clk_i(clk), .reset_ni(reset_n), .clear_i(clear), .dut_reset_i(dut_reset),
        .dut_enable_i(dut_enable), .dut_mode_i(dut_mode), .dut_d_i(dut_d), .dut_q_i(dut_q),
        .dut_load_i(dut_load), .q_exp_o(q_exp1), .rco_exp_o(rco1), .synced_o(synced1),
        .mismatch_o(mis1), .fail_o(fail1), .err_count_o(err1), .chk_count_o(chk1)
`ifdef CHK_FIRST_ERR_LOG_EN
        , .first_exp_q_o(fexp1), .first_act_q_o(fact1), .first_err_cyc_o(fcyc1)
`endif
    );

    // Counter behaviour from its rules, in plain integer arithmetic: returns {q, load, rco}.
    function automatic logic [5:0] next_ctr(input int q, input bit ld, input bit rco,
                                            input bit rst, input bit en, input int mode,
                                            input int d);
        int nq;
        bit nl, nr;
        logic [3:0] q4;
        nq = q; nl = ld; nr = rco;
        if (rst) begin
            nq = 0; nl = 0; nr = 0;
        end else if (!en) begin
            nq = 0; nl = (mode == 3);
            if (mode == 3) nr = 0;
        end else begin
            case (mode)
                0: begin nr = (q == 15); nq = (q + 1) % 16;  nl = 0; end
                1: begin nr = (q == 0);  nq = (q + 15) % 16; nl = 0; end
                2: begin nr = (q <= 2);  nq = (q + 13) % 16; nl = 0; end
                default: begin nq = d; nl = 1; nr = 0; end
            endcase
        end
        q4 = 4'(nq);
        return {q4, nl, nr};
    endfunction

    task automatic tick();
        bit rst_s, en_s, clr_s, ld_s, det;
        int mode_s, d_s, q_s;
        logic [5:0] nx;
        rst_s = dut_reset; en_s = dut_enable; clr_s = clear; ld_s = dut_load;
        mode_s = int'(dut_mode); d_s = int'(dut_d); q_s = int'(dut_q);
        det = rst_s || !en_s || (mode_s == 3);
        for (int i = 0; i < 2; i++) begin
            mis[i] = 0;
            if (clr_s) begin
                st[i] = 0; errs[i] = 0; chks[i] = 0;
                if (i == 0) begin logged = 0; fexp = 0; fact = 0; fcyc = 0; end
            end else if (st[i] == 0) begin
                if (det) st[i] = 1;
            end else if (st[i] == 1) begin
                bit m;
                m = (q_s != rq) || (ld_s != rload);
                if (chks[i] < 65535) chks[i]++;
                if (m) begin
                    mis[i] = 1;
                    if (errs[i] < 255) errs[i]++;
                    if (i == 1) st[i] = 2;
                    if (i == 0 && !logged) begin
                        logged = 1; fexp = rq; fact = q_s; fcyc = chks[0];
                    end
                end
            end
        end
        nx = next_ctr(rq, rload, rrco, rst_s, en_s, mode_s, d_s);
        rq = int'(nx[5:2]); rload = nx[1]; rrco = nx[0];
        nx = next_ctr(cq, cload, crco, rst_s, en_s, mode_s, d_s);
        cq = int'(nx[5:2]); cload = nx[1]; crco = nx[0];
        @(posedge clk);
        #1;
        dut_q = 4'(cq);
        dut_load = cload;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin st[i] = 0; errs[i] = 0; chks[i] = 0; mis[i] = 0; end
        rq = 0; rload = 0; rrco = 0;
        logged = 0; fexp = 0; fact = 0; fcyc = 0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({q_exp0, rco0, synced0, mis0, fail0, err0, chk0} !== 33'd0) begin
            n_errors++;
            $display("FAIL reset_outs0: got %h required 0",
                     {q_exp0, rco0, synced0, mis0, fail0, err0, chk0});
        end
        n_checks++;
        if ({q_exp1, rco1, synced1, mis1, fail1, err1, chk1} !== 33'd0) begin
            n_errors++;
            $display("FAIL reset_outs1: got %h required 0",
                     {q_exp1, rco1, synced1, mis1, fail1, err1, chk1});
        end
`ifdef CHK_FIRST_ERR_LOG_EN
        n_checks++;
        if ({fexp0, fact0, fcyc0} !== 24'd0) begin
            n_errors++;
            $display("FAIL reset_log: got %h required 0", {fexp0, fact0, fcyc0});
        end
`endif
        apply_reset();
    endtask

    task automatic test_count_up();
        dut_reset = 1; dut_enable = 1; dut_mode = 2'b00;
        tick();
        n_checks++;
        if (synced0 !== 1'b1) begin
            n_errors++; $display("FAIL sync_on_reset: got %b required 1", synced0);
        end
        dut_reset = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if (q_exp0 !== 4'(rq) || rco0 !== rrco) begin
                n_errors++;
                $display("FAIL up_q_rco step %0d: got %0d/%b required %0d/%b",
                         i, q_exp0, rco0, rq, rrco);
            end
            n_checks++;
            if (mis0 !== 1'b0 || mis1 !== 1'b0) begin
                n_errors++; $display("FAIL up_no_mismatch step %0d: got %b%b required 00",
                                     i, mis0, mis1);
            end
            if (i == 16) begin
                n_checks++;
                if (q_exp0 !== 4'd0 || rco0 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL up_wrap: got %0d/%b required 0/1", q_exp0, rco0);
                end
            end
        end
        n_checks++;
        if (chk0 !== 16'd20 || err0 !== 8'd0 || synced0 !== 1'b1) begin
            n_errors++;
            $display("FAIL up_counts: got chk=%0d err=%0d sync=%b required 20/0/1",
                     chk0, err0, synced0);
        end
    endtask

    task automatic test_load_m3();
        logic [3:0] exp_q [3];
        bit         exp_r [3];
        exp_q = '{4'd1, 4'd14, 4'd11};
        exp_r = '{1'b0, 1'b1, 1'b0};
        dut_enable = 1; dut_mode = 2'b11; dut_d = 4'h1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) dut_mode = 2'b10;
            tick();
            n_checks++;
            if (q_exp0 !== exp_q[i] || rco0 !== exp_r[i] || mis0 !== 1'b0) begin
                n_errors++;
                $display("FAIL load_m3 step %0d: got %0d/%b/%b required %0d/%b/0",
                         i, q_exp0, rco0, mis0, exp_q[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_inject();
        int e0, c1;
        dut_enable = 1; dut_mode = 2'b11; dut_d = 4'h5;
        tick();
        n_checks++;
        if (q_exp0 !== 4'h5 || mis0 !== 1'b0) begin
            n_errors++; $display("FAIL inj_pre: got %0d/%b required 5/0", q_exp0, mis0);
        end
        e0 = int'(err0);
        dut_q = 4'h7;
        tick();
        n_checks++;
        if (mis0 !== 1'b1 || int'(err0) !== e0 + 1 || synced0 !== 1'b1) begin
            n_errors++;
            $display("FAIL inj_pulse0: got mis=%b err=%0d sync=%b required 1/%0d/1",
                     mis0, err0, synced0, e0 + 1);
        end
        n_checks++;
        if (mis1 !== 1'b1 || fail1 !== 1'b1 || err1 !== 8'd1 || synced1 !== 1'b0) begin
            n_errors++;
            $display("FAIL inj_stop1: got mis=%b fail=%b err=%0d sync=%b required 1/1/1/0",
                     mis1, fail1, err1, synced1);
        end
        c1 = int'(chk1);
        dut_mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (mis0 !== 1'b0 || int'(err0) !== e0 + 1 || synced0 !== 1'b1) begin
                n_errors++;
                $display("FAIL inj_track0 %0d: got mis=%b err=%0d sync=%b", i, mis0, err0,
                         synced0);
            end
            n_checks++;
            if (fail1 !== 1'b1 || err1 !== 8'd1 || int'(chk1) !== c1 || mis1 !== 1'b0) begin
                n_errors++;
                $display("FAIL inj_frozen1 %0d: got fail=%b err=%0d chk=%0d required 1/1/%0d",
                         i, fail1, err1, chk1, c1);
            end
        end
        clear = 1;
        tick();
        clear = 0;
        n_checks++;
        if (fail1 !== 1'b0 || synced1 !== 1'b0 || err1 !== 8'd0 || chk1 !== 16'd0) begin
            n_errors++;
            $display("FAIL clear1: got fail=%b sync=%b err=%0d chk=%0d required 0/0/0/0",
                     fail1, synced1, err1, chk1);
        end
    endtask

    task automatic test_unsync();
        apply_reset();
        dut_reset = 0; dut_enable = 1; dut_mode = 2'b00;
        for (int i = 0; i < 10; i++) begin
            dut_q = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (synced0 !== 1'b0 || chk0 !== 16'd0 || mis0 !== 1'b0) begin
                n_errors++;
                $display("FAIL unsync %0d: got sync=%b chk=%0d mis=%b required 0/0/0",
                         i, synced0, chk0, mis0);
            end
        end
        dut_enable = 0;
        tick();
        n_checks++;
        if (synced0 !== 1'b1 || synced1 !== 1'b1) begin
            n_errors++; $display("FAIL resync: got %b%b required 11", synced0, synced1);
        end
        dut_enable = 1;
    endtask

`ifdef CHK_FIRST_ERR_LOG_EN
    task automatic test_first_err();
        clear = 1;
        tick();
        clear = 0;
        dut_reset = 1; dut_enable = 1; dut_mode = 2'b00;
        tick();
        dut_reset = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n == 3 || n == 9) dut_q = dut_q ^ 4'h5;
            tick();
        end
        n_checks++;
        if (fcyc0 !== 16'd3 || err0 !== 8'd2) begin
            n_errors++;
            $display("FAIL first_cyc: got cyc=%0d err=%0d required 3/2", fcyc0, err0);
        end
        n_checks++;
        if (fexp0 !== 4'd2 || fact0 !== 4'd7 || int'(fexp0) !== fexp || int'(fact0) !== fact) begin
            n_errors++;
            $display("FAIL first_vals: got exp=%0d act=%0d required 2/7", fexp0, fact0);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            dut_reset  = ($urandom_range(0, 15) == 0);
            dut_enable = ($urandom_range(0, 7) != 0);
            dut_mode   = 2'($urandom_range(0, 3));
            dut_d      = 4'($urandom_range(0, 15));
            clear      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) dut_q = dut_q ^ 4'($urandom_range(1, 15));
            if ($urandom_range(0, 19) == 0) dut_load = ~dut_load;
            tick();
            n_checks++;
            if (q_exp0 !== 4'(rq) || rco0 !== rrco || q_exp1 !== 4'(rq)) begin
                n_errors++;
                $display("FAIL rnd_model %0d: got %0d/%b required %0d/%b", i, q_exp0, rco0,
                         rq, rrco);
            end
            n_checks++;
            if (synced0 !== (st[0] == 1) || fail0 !== 1'b0 || mis0 !== mis[0] ||
                int'(err0) !== errs[0] || int'(chk0) !== chks[0]) begin
                n_errors++;
                $display("FAIL rnd_inst0 %0d: got s=%b m=%b e=%0d c=%0d required %0d/%b/%0d/%0d",
                         i, synced0, mis0, err0, chk0, st[0], mis[0], errs[0], chks[0]);
            end
            n_checks++;
            if (synced1 !== (st[1] == 1) || fail1 !== (st[1] == 2) || mis1 !== mis[1] ||
                int'(err1) !== errs[1] || int'(chk1) !== chks[1]) begin
                n_errors++;
                $display("FAIL rnd_inst1 %0d: got s=%b f=%b m=%b e=%0d c=%0d required st=%0d %b/%0d/%0d",
                         i, synced1, fail1, mis1, err1, chk1, st[1], mis[1], errs[1], chks[1]);
            end
        end
        clear = 0;
    endtask

    initial begin
        reset_n = 1'b0; clear = 0;
        dut_reset = 0; dut_enable = 1; dut_mode = 2'b00; dut_d = 4'h0;
        cq = 9; cload = 0; crco = 0;
        dut_q = 4'(cq); dut_load = cload;
        test_reset();
        test_count_up();
        test_load_m3();
        test_inject();
        test_unsync();
`ifdef CHK_FIRST_ERR_LOG_EN
        test_first_err();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Synthesizable on-chip monitor for the 4-bit multi-mode counter (+1, -1, -3, parallel load).
- Observes the counter's control inputs (reset, enable, mode, D) and its outputs (Q, load).
- Maintains its own reference model and flags any cycle where the counter output differs from the prediction.
- Sits beside the counter in the part_D test harness; the counter drives, this block reads and judges.

Parameters:
- Q_P_ONE, 2'b00, mode encoding for count up by 1
- Q_M_ONE, 2'b01, mode encoding for count down by 1
- Q_M_THREE, 2'b10, mode encoding for count down by 3
- Q_D, 2'b11, mode encoding for parallel load of D
- ERR_W, 8, width of the saturating error counter
- STOP_ON_ERR, 0, 1 = enter FAIL on first mismatch and stop checking; 0 = keep checking

Ports:
- clk  input  1  single clock; all sampling on rising edge
- reset  input  1  asynchronous, active-low checker reset (0 = reset)
- clear  input  1  synchronous; forces UNSYNC and zeroes err_count and chk_count
- dut_reset  input  1  counter's synchronous active-high reset, as driven to the counter
- dut_enable  input  1  counter enable, as driven
- dut_mode  input  2  counter mode, as driven
- dut_D  input  4  counter load data, as driven
- dut_Q  input  4  counter count output
- dut_load  input  1  counter load flag output
- q_exp  output  4  model's predicted Q
- rco_exp  output  1  model's predicted rco; for waveform comparison only, not checked
- synced  output  1  high while in TRACK
- mismatch  output  1  one-cycle pulse on detected error
- fail  output  1  high while in FAIL
- err_count  output  ERR_W  saturating mismatch count
- chk_count  output  16  saturating count of compared cycles

Behaviour:
- Reset (reset=0, async): state UNSYNC; all outputs 0; model Q/load/rco = 0.
- Model update on every rising edge, regardless of state, using the same sampled inputs as the counter:
  - dut_reset=1: Q=0, load=0, rco=0.
  - dut_enable=0: Q=0; load=(mode==Q_D); rco=0 if mode==Q_D, else rco is held.
  - Q_P_ONE: Q=Q+1 mod 16; rco=(old Q==15); load=0.
  - Q_M_ONE: Q=Q-1 mod 16; rco=(old Q==0); load=0.
  - Q_M_THREE: Q=Q-3 mod 16, so 1 becomes 14 and 2 becomes 15; rco=(old Q<=2); load=0.
  - Q_D: Q=D; load=1; rco=0.
- All arithmetic is 4-bit wrap-around.
- Comparison uses the model state registered at edge k against dut_Q/dut_load sampled at edge k+1 (both hold the post-edge-k values).
  - mismatch pulses at edge k+1 when dut_Q!=model Q or dut_load!=model load.
  - Error latency is 1 cycle.
- State machine:
  - UNSYNC: no comparisons. Go to TRACK after any edge where the model became deterministic: dut_reset=1, dut_enable=0, or mode==Q_D.
  - TRACK: compare every cycle; chk_count++ (saturates at 16'hFFFF).
    - On mismatch: err_count++ (saturates at all-ones); stay in TRACK if STOP_ON_ERR=0, else go to FAIL.
  - FAIL: no comparisons, counters frozen, fail=1. Leave only via clear (to UNSYNC) or reset.
- clear has priority over compare in the same cycle: no mismatch pulse, counters zero, state UNSYNC. The model still updates that cycle.
- dut_reset while in TRACK is an ordinary predicted event; the counter must show Q=0, load=0 at the next edge.
- Checker reset mid-operation discards all history; it resyncs by the UNSYNC rules above.

Optional Feature:
- Macro CHK_FIRST_ERR_LOG_EN.
- Defined: adds outputs first_exp_q[3:0], first_act_q[3:0], first_err_cyc[15:0].
  - Captured on the first mismatch after reset/clear: first_err_cyc is the chk_count value at that mismatch.
  - Held until reset or clear; all 0 at reset.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Test Plan:
- Hold dut_reset=1 for 1 cycle, then mode=Q_P_ONE, enable=1 for 20 cycles with a correct counter -> synced=1, mismatch never pulses, err_count=0, chk_count=20, q_exp wraps 15 to 0 with rco_exp=1 on the wrap.
- Load D=4'h1 (mode=Q_D), then Q_M_THREE for 2 cycles -> q_exp sequence 1, 14, 11; rco_exp=1 only after the 1 to 14 step.
- Inject dut_Q forced to 4'h7 when 4'h5 is expected, STOP_ON_ERR=0 -> mismatch pulses exactly 1 cycle later, err_count=1, tracking continues.
- Same injection with STOP_ON_ERR=1 -> fail=1, err_count frozen at 1; pulse clear -> fail=0, synced=0, err_count=0.
- Out of reset with no dut_reset, enable=1, mode=Q_P_ONE for 10 cycles -> synced stays 0, chk_count=0; then enable=0 for 1 cycle -> synced=1.
- CHK_FIRST_ERR_LOG_EN defined: two mismatches at chk_count 3 and 9 -> first_err_cyc=3 with first_exp_q/first_act_q from the first error; both held after the second mismatch.
